// File: rtl/env_pkg.sv
// env_pkg: shared types, constants and helpers for the environment initialiser.
// Revision 1.0
`default_nettype none

package env_pkg;

  localparam int ENV_ROWS = 16;
  localparam int ENV_COLS = 16;

  // Widest row the popcount helper handles; wider rows must raise this.
  localparam int POP_MAXW = 256;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [1:0] {
    MODE_CLEAR   = 2'd0,
    MODE_RAND    = 2'd1,
    MODE_LOAD    = 2'd2,
    MODE_ILLEGAL = 2'd3
  } env_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RGEN  = 3'd2,
    ST_RWR   = 3'd3,
    ST_LOAD  = 3'd4,
    ST_DONE  = 3'd5
  } env_state_e;

  typedef logic [ENV_COLS-1:0]              env_row_t;
  typedef env_row_t [ENV_ROWS-1:0]          environment_t;

  function automatic int unsigned popcount(input logic [POP_MAXW-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POP_MAXW; i++) begin
      n += {31'd0, v[i]};
    end
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/env_lfsr.sv
// env_lfsr: 32-bit right-shifting Galois LFSR with load, step enable and zero-seed guard.
// Revision 1.0
`default_nettype none

module env_lfsr
  import env_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        step,
  output logic        next_bit
);

  logic [31:0] state_q;
  logic [31:0] state_d;
  logic [31:0] stepped;

  always_comb begin
    stepped  = {1'b0, state_q[31:1]} ^ (state_q[0] ? LFSR_TAPS : 32'h0);
    next_bit = stepped[0];
    state_d  = state_q;
    if (load) begin
      // An all-zero state would lock up, so a zero seed becomes 1.
      state_d = (seed == 32'h0) ? 32'h1 : seed;
    end else if (step) begin
      state_d = stepped;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= 32'h1;
    else        state_q <= state_d;
  end

endmodule

`default_nettype wire

// File: rtl/env_init_ctrl.sv
// env_init_ctrl: fills a ROWS x COLS environment one row per write (clear / random / load).
// Revision 1.0
`default_nettype none

module env_init_ctrl
  import env_pkg::*;
#(
  parameter int ROWS = ENV_ROWS,
  parameter int COLS = ENV_COLS,
  parameter int RW   = $clog2(ROWS),
  parameter int PW   = $clog2(ROWS*COLS+1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [1:0]      mode,
  input  logic [31:0]     seed,
  input  logic [COLS-1:0] load_data,
  input  logic            load_valid,
  output logic            load_ready,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic            cnt_clear,
  output logic            wr_en,
  output logic [RW-1:0]   wr_row,
  output logic [COLS-1:0] wr_data,
  output logic [PW-1:0]   pop_count
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  env_state_e      state_q, state_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic [COLS-1:0] row_buf_q, row_buf_d;
  logic            wr_en_q, wr_en_d;
  logic [RW-1:0]   wr_row_q, wr_row_d;
  logic [COLS-1:0] wr_data_q, wr_data_d;
  logic [PW-1:0]   pop_q, pop_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            cnt_clear_q, cnt_clear_d;
  logic            load_ready_q, load_ready_d;
  logic            lfsr_load, lfsr_step, lfsr_bit;
  logic            last_row;

  env_lfsr u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (lfsr_load),
    .seed     (seed),
    .step     (lfsr_step),
    .next_bit (lfsr_bit)
  );

  assign last_row = (row_q == RW'(ROWS-1));

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    row_buf_d    = row_buf_q;
    wr_en_d      = 1'b0;
    wr_row_d     = wr_row_q;
    wr_data_d    = wr_data_q;
    pop_d        = pop_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    cnt_clear_d  = 1'b0;
    load_ready_d = 1'b0;
    lfsr_load    = 1'b0;
    lfsr_step    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start && !abort) begin
          if (mode == MODE_ILLEGAL) begin
            err_d = 1'b1;
          end else begin
            lfsr_load   = 1'b1;
            row_d       = '0;
            col_d       = '0;
            pop_d       = '0;
            cnt_clear_d = 1'b1;
            busy_d      = 1'b1;
            case (mode)
              MODE_CLEAR: state_d = ST_CLEAR;
              MODE_RAND:  state_d = ST_RGEN;
              default: begin
                state_d      = ST_LOAD;
                load_ready_d = 1'b1;
              end
            endcase
          end
        end
      end
      ST_CLEAR: begin
        wr_en_d   = 1'b1;
        wr_row_d  = row_q;
        wr_data_d = '0;
        row_d     = row_q + 1'b1;
        if (last_row) state_d = ST_DONE;
      end
      ST_RGEN: begin
        // New bits enter at the MSB so the first step ends up in column 0.
        lfsr_step = 1'b1;
        row_buf_d = {lfsr_bit, row_buf_q[COLS-1:1]};
        col_d     = col_q + 1'b1;
        if (col_q == CW'(COLS-1)) begin
          col_d   = '0;
          state_d = ST_RWR;
        end
      end
      ST_RWR: begin
        wr_en_d   = 1'b1;
        wr_row_d  = row_q;
        wr_data_d = row_buf_q;
        row_d     = row_q + 1'b1;
        state_d   = last_row ? ST_DONE : ST_RGEN;
      end
      ST_LOAD: begin
        load_ready_d = 1'b1;
        if (load_valid && load_ready_q) begin
          wr_en_d   = 1'b1;
          wr_row_d  = row_q;
          wr_data_d = load_data;
          row_d     = row_q + 1'b1;
          if (last_row) begin
            state_d      = ST_DONE;
            load_ready_d = 1'b0;
          end
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort discards whatever this edge would have written or advanced.
    if (abort && (state_q != ST_IDLE)) begin
      state_d      = ST_IDLE;
      busy_d       = 1'b0;
      done_d       = 1'b0;
      wr_en_d      = 1'b0;
      wr_row_d     = wr_row_q;
      wr_data_d    = wr_data_q;
      load_ready_d = 1'b0;
      row_d        = row_q;
      col_d        = col_q;
      row_buf_d    = row_buf_q;
      lfsr_step    = 1'b0;
    end

    if (wr_en_d) begin
      pop_d = pop_q + PW'(popcount(POP_MAXW'(wr_data_d)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      row_q        <= '0;
      col_q        <= '0;
      row_buf_q    <= '0;
      wr_en_q      <= 1'b0;
      wr_row_q     <= '0;
      wr_data_q    <= '0;
      pop_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      cnt_clear_q  <= 1'b0;
      load_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      row_buf_q    <= row_buf_d;
      wr_en_q      <= wr_en_d;
      wr_row_q     <= wr_row_d;
      wr_data_q    <= wr_data_d;
      pop_q        <= pop_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      cnt_clear_q  <= cnt_clear_d;
      load_ready_q <= load_ready_d;
    end
  end

  assign load_ready = load_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign cnt_clear  = cnt_clear_q;
  assign wr_en      = wr_en_q;
  assign wr_row     = wr_row_q;
  assign wr_data    = wr_data_q;
  assign pop_count  = pop_q;

endmodule

`default_nettype wire

// File: tb/tb_env_init_ctrl.sv
// tb_env_init_ctrl: directed self-checking bench for env_init_ctrl at ROWS = COLS = 16.
// Revision 1.0
`default_nettype none

module tb_env_init_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, load_valid;
  logic [1:0]  mode;
  logic [31:0] seed;
  logic [15:0] load_data;
  logic        load_ready, busy, done, err, cnt_clear, wr_en;
  logic [3:0]  wr_row;
  logic [15:0] wr_data;
  logic [8:0]  pop_count;

  int checks = 0;
  int errors = 0;

  logic [3:0]  q_row[$];
  logic [15:0] q_data[$];
  int          n_cc, n_done, n_err;
  logic [15:0] exp_grid[16];
  logic [15:0] grid_a[16];
  int          e;
  int          exp_pop;

  env_init_ctrl #(.ROWS(16), .COLS(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .mode       (mode),
    .seed       (seed),
    .load_data  (load_data),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .cnt_clear  (cnt_clear),
    .wr_en      (wr_en),
    .wr_row     (wr_row),
    .wr_data    (wr_data),
    .pop_count  (pop_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) begin
        q_row.push_back(wr_row);
        q_data.push_back(wr_data);
      end
      if (cnt_clear) n_cc++;
      if (done)      n_done++;
      if (err)       n_err++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    q_row.delete();
    q_data.delete();
    n_cc   = 0;
    n_done = 0;
    n_err  = 0;
  endtask

  // Leaves the bench at the falling edge just after the start-sampling edge.
  task automatic start_run(input logic [1:0] m, input logic [31:0] s);
    @(negedge clk);
    clear_mon();
    mode  = m;
    seed  = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int edges);
    edges = 0;
    while (!done && edges < limit) begin
      @(negedge clk);
      edges++;
    end
    chk("done_seen", {31'd0, done}, 32'd1);
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_nwrites"}, q_row.size(), 32'd16);
    for (int i = 0; i < q_row.size() && i < 16; i++) begin
      chk({tag, "_row"},  {28'd0, q_row[i]},  i);
      chk({tag, "_data"}, {16'd0, q_data[i]}, {16'd0, exp_grid[i]});
    end
  endtask

  task automatic build_rand(input logic [31:0] s, output int pop);
    logic [31:0] l;
    logic [15:0] r;
    pop = 0;
    l   = (s == 32'h0) ? 32'h1 : s;
    for (int ri = 0; ri < 16; ri++) begin
      r = 16'h0;
      for (int c = 0; c < 16; c++) begin
        if (l[0]) l = (l >> 1) ^ 32'h8020_0003;
        else      l = l >> 1;
        r = {l[0], r[15:1]};
      end
      exp_grid[ri] = r;
      pop += $countones(r);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 2'd0;
    seed = 32'h0; load_valid = 1'b0; load_data = 16'h0;
    clear_mon();
    repeat (3) @(negedge clk);
    chk("rst_busy",       {31'd0, busy},       0);
    chk("rst_done",       {31'd0, done},       0);
    chk("rst_wr_en",      {31'd0, wr_en},      0);
    chk("rst_load_ready", {31'd0, load_ready}, 0);
    chk("rst_cnt_clear",  {31'd0, cnt_clear},  0);
    chk("rst_pop",        {23'd0, pop_count},  0);
    rst_n = 1'b1;

    // Clear mode
    for (int i = 0; i < 16; i++) exp_grid[i] = 16'h0;
    start_run(2'd0, 32'h0);
    chk("clr_cnt_clear", {31'd0, cnt_clear}, 1);
    chk("clr_busy",      {31'd0, busy},      1);
    wait_done(100, e);
    chk("clr_latency", e, 17);
    chk("clr_busy_at_done", {31'd0, busy}, 0);
    chk("clr_pop", {23'd0, pop_count}, 0);
    check_writes("clr");
    chk("clr_ncc", n_cc, 1);
    @(negedge clk);
    chk("clr_done_pulse", {31'd0, done}, 0);

    // Load with valid held, plus an ignored start mid-run
    for (int i = 0; i < 16; i++) exp_grid[i] = 16'hFFFF;
    load_valid = 1'b1; load_data = 16'hFFFF;
    start_run(2'd2, 32'h0);
    chk("ld_ready", {31'd0, load_ready}, 1);
    repeat (4) @(negedge clk);
    start = 1'b1; mode = 2'd0;
    @(negedge clk);
    start = 1'b0;
    wait_done(100, e);
    chk("ld_latency_rest", e, 12);
    load_valid = 1'b0;
    chk("ld_pop", {23'd0, pop_count}, 256);
    chk("ld_ready_at_done", {31'd0, load_ready}, 0);
    check_writes("ld");
    chk("ld_ncc", n_cc, 1);

    // Load with valid every other cycle
    for (int i = 0; i < 16; i++) exp_grid[i] = {4{i[3:0]}};
    start_run(2'd2, 32'h0);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      load_valid = 1'b1;
      load_data  = exp_grid[k];
      @(negedge clk);
      load_valid = 1'b0;
    end
    wait_done(10, e);
    chk("gap_pop", {23'd0, pop_count}, 128);
    check_writes("gap");

    // Illegal mode
    start_run(2'd3, 32'h0);
    chk("ill_err",       {31'd0, err},       1);
    chk("ill_busy",      {31'd0, busy},      0);
    chk("ill_cnt_clear", {31'd0, cnt_clear}, 0);
    @(negedge clk);
    chk("ill_err_pulse", {31'd0, err}, 0);
    repeat (5) @(negedge clk);
    chk("ill_nwrites", q_row.size(), 0);
    chk("ill_ncc",     n_cc, 0);
    chk("ill_nerr",    n_err, 1);

    // Random: zero seed behaves as seed 1
    build_rand(32'h1, exp_pop);
    start_run(2'd1, 32'h0);
    wait_done(1000, e);
    chk("r0_latency", e, 273);
    check_writes("r0");
    chk("r0_pop", {23'd0, pop_count}, exp_pop);
    for (int i = 0; i < 16; i++) grid_a[i] = (i < q_data.size()) ? q_data[i] : 16'hxxxx;
    start_run(2'd1, 32'h1);
    wait_done(1000, e);
    check_writes("r1");
    for (int i = 0; i < q_data.size() && i < 16; i++)
      chk("r0_vs_r1", {16'd0, q_data[i]}, {16'd0, grid_a[i]});

    build_rand(32'hACE1, exp_pop);
    start_run(2'd1, 32'hACE1);
    wait_done(1000, e);
    chk("race1_latency", e, 273);
    check_writes("race1");
    chk("race1_pop", {23'd0, pop_count}, exp_pop);

    // Abort at row 5 of clear, with a start in the same cycle
    start_run(2'd0, 32'h0);
    repeat (5) @(negedge clk);
    abort = 1'b1; start = 1'b1; mode = 2'd2;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    chk("abc_busy",  {31'd0, busy},  0);
    chk("abc_wr_en", {31'd0, wr_en}, 0);
    repeat (20) @(negedge clk);
    chk("abc_nwrites", q_row.size(), 5);
    for (int i = 0; i < q_row.size(); i++) chk("abc_row", {28'd0, q_row[i]}, i);
    chk("abc_ndone", n_done, 0);
    chk("abc_ncc",   n_cc, 1);
    chk("abc_busy_later", {31'd0, busy}, 0);

    // Abort mid-load keeps the partial population
    load_valid = 1'b1; load_data = 16'hFFFF;
    start_run(2'd2, 32'h0);
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; load_valid = 1'b0;
    chk("abl_ready", {31'd0, load_ready}, 0);
    chk("abl_busy",  {31'd0, busy}, 0);
    chk("abl_pop",   {23'd0, pop_count}, 80);
    repeat (3) @(negedge clk);
    chk("abl_nwrites", q_row.size(), 5);
    chk("abl_ndone",   n_done, 0);

    // Abort and start together in IDLE: start ignored
    clear_mon();
    abort = 1'b1; start = 1'b1; mode = 2'd0;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    chk("idle_ab_busy",      {31'd0, busy},      0);
    chk("idle_ab_cnt_clear", {31'd0, cnt_clear}, 0);
    repeat (3) @(negedge clk);
    chk("idle_ab_nwrites", q_row.size(), 0);
    chk("idle_ab_pop_held", {23'd0, pop_count}, 80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
